// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size encodings, FSM states, wait-counter width.
// Latency: n/a (types and one pure helper function only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  // Alignment rule: bytes never misalign, halves need addr[0]==0,
  // words need addr[1:0]==0, and the reserved size is always rejected.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: extracts/extends a loaded byte or half, merges store data into a word.
// Latency: purely combinational.
// Backpressure: none, stateless.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Load path: pick the addressed lane and zero- or sign-extend it.
  always_comb begin
    shifted   = mem_word >> {lane, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = mem_word;
    case (size_e'(size))
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = mem_word;
    endcase
  end

  // Store path: overwrite only the addressed lanes of the current word.
  always_comb begin
    store_word = mem_word;
    case (size_e'(size))
      SZ_BYTE: begin
        case (lane)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_word = wdata;
      default: store_word = mem_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory responder with wait states, error checks and a one-cycle ready pulse.
// Latency: WAIT_STATES+2 cycles request-to-ready on success, 1 cycle on address/alignment error.
// Backpressure: req_i is only sampled in IDLE; busy_o high means requests are ignored.
// Optional build macro DMEM_ERR_STICKY_EN: error flags hold once set until reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        err_addr_o,
  output logic        err_mis_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q, rdata_q;
  logic             err_addr_q, err_mis_q;
  logic             accept, req_err_addr, req_err_mis;
  logic [31:0]      rd_word, load_data, store_word;

  // Memory contents are intentionally never reset.
  logic [31:0] mem [DEPTH_WORDS];

  assign accept       = (state_q == ST_IDLE) && req_i;
  // addr >= 4*DEPTH_WORDS is exactly "any bit above the word index is set".
  assign req_err_addr = (addr_i[31:AW+2] != '0);
  assign req_err_mis  = is_misaligned(size_e'(size_i), addr_i[1:0]);
  assign rd_word      = mem[addr_q[AW+1:2]];

  dmem_lane_align u_lane_align (
    .mem_word    (rd_word),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // State register; reset aborts anything in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: errors bypass the memory entirely; wait states are counted down.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (req_err_addr || req_err_mis) state_d = ST_RESP;
          else if (WAIT_STATES > 0)        state_d = ST_WAIT;
          else                             state_d = ST_ACCESS;
        end
      end
      ST_WAIT:   if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: rdata is only exposed during the ready pulse, so it is 0 elsewhere.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    ready_o = (state_q == ST_RESP);
    rdata_o = (state_q == ST_RESP) ? rdata_q : 32'h0;
  end

  // Request capture, wait counter and load result register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        size_q  <= size_i;
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
        cnt_q   <= CNT_W'(WAIT_STATES);
        rdata_q <= 32'h0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == ST_ACCESS) rdata_q <= we_q ? 32'h0 : load_data;
    end
  end

  // Error flags: captured at acceptance, so they are stable through RESP.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_addr_q <= 1'b0;
      err_mis_q  <= 1'b0;
    end else begin
`ifdef DMEM_ERR_STICKY_EN
      if (accept) begin
        err_addr_q <= err_addr_q | req_err_addr;
        err_mis_q  <= err_mis_q  | req_err_mis;
      end
`else
      if (accept) begin
        err_addr_q <= req_err_addr;
        err_mis_q  <= req_err_mis;
      end else if (state_q == ST_RESP) begin
        err_addr_q <= 1'b0;
        err_mis_q  <= 1'b0;
      end
`endif
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_mis_o  = err_mis_q;

  // Memory write happens only on the ACCESS edge, so a reset before it leaves memory intact.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_ACCESS && we_q) mem[addr_q[AW+1:2]] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (DEPTH_WORDS=256, WAIT_STATES=1).
// Latency: checks request-to-ready cycle counts against hand-computed values.
// Backpressure: holds req_i high with scrambled fields while busy to confirm they are ignored.
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, we_i, unsigned_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        busy_o, ready_o, err_addr_o, err_mis_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int fails  = 0;
  logic acc_a = 1'b0;
  logic acc_m = 1'b0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .rdata_o    (rdata_o),
    .err_addr_o (err_addr_o),
    .err_mis_o  (err_mis_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          lat;
    logic        ea;
    logic        em;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                              input int lat, input logic ea, input logic em);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rdata = rdata; v.lat = lat; v.ea = ea; v.em = em;
    return v;
  endfunction

  // Issue one request, hold req high with garbage while busy, then check the response and the idle cycle after.
  task automatic run(input vec_t v, input string nm);
    int   lat;
    logic ea_exp, em_exp, ea_idle, em_idle;
    @(negedge clk_i);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    size_i = v.size; unsigned_i = v.uns;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      we_i = ~v.we; addr_i = v.addr ^ 32'h0000_0004; wdata_i = ~v.wdata;
      size_i = v.size ^ 2'b01; unsigned_i = ~v.uns;
    end while (!ready_o && lat < 40);
    req_i = 1'b0;
`ifdef DMEM_ERR_STICKY_EN
    acc_a = acc_a | v.ea;  acc_m = acc_m | v.em;
    ea_exp = acc_a; em_exp = acc_m; ea_idle = acc_a; em_idle = acc_m;
`else
    ea_exp = v.ea; em_exp = v.em; ea_idle = 1'b0; em_idle = 1'b0;
`endif
    chk({nm, "_lat"},      32'(lat),        32'(v.lat));
    chk({nm, "_rdata"},    rdata_o,         v.rdata);
    chk({nm, "_err_addr"}, 32'(err_addr_o), 32'(ea_exp));
    chk({nm, "_err_mis"},  32'(err_mis_o),  32'(em_exp));
    @(negedge clk_i);
    chk({nm, "_idle_rdy"},  32'({busy_o, ready_o}), 32'h0);
    chk({nm, "_idle_rd"},   rdata_o, 32'h0);
    chk({nm, "_idle_errs"}, 32'({err_addr_o, err_mis_o}), 32'({ea_idle, em_idle}));
  endtask

  initial begin
    vec_t v;
    //              we    addr          wdata         size   uns  rdata         lat ea    em
    vecs[0]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 32'h0000_0013, 32'h1234_5680, 2'b00, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 32'h0000_0013, 32'h0,         2'b00, 1'b0, 32'hFFFF_FF80, 3, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 32'h0000_0013, 32'h0,         2'b00, 1'b1, 32'h0000_0080, 3, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 3, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 32'h0000_0011, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 3, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b0, 32'hFFFF_80AD, 3, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 32'h0000_0010, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF, 3, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 32'h0000_0012, 32'hFFFF_1234, 2'b01, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h1234_BEEF, 3, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 32'h0000_0011, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFBE, 3, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 32'h0000_0020, 32'h55AA_55AA, 2'b10, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 32'h0000_0000, 32'h1111_1111, 2'b10, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 32'h0000_03FC, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 3, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 32'h0000_0020, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 32'h0000_0022, 32'h0,         2'b10, 1'b0, 32'h0000_0000, 1, 1'b0, 1'b1);
    vecs[19] = mk(1'b1, 32'h0000_0400, 32'h2222_2222, 2'b10, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b0);
    vecs[20] = mk(1'b0, 32'h0000_0000, 32'h0,         2'b10, 1'b0, 32'h1111_1111, 3, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 32'h0000_0401, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b1);
    vecs[22] = mk(1'b1, 32'h0000_0021, 32'h0000_FFFF, 2'b01, 1'b0, 32'h0000_0000, 1, 1'b0, 1'b1);
    vecs[23] = mk(1'b0, 32'h0000_0020, 32'h0,         2'b10, 1'b0, 32'h55AA_55AA, 3, 1'b0, 1'b0);

    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    size_i = 2'b00; unsigned_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outs", {busy_o, ready_o, err_addr_o, err_mis_o, rdata_o[27:0]}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 24; i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset during the wait state of a store must abort it without touching memory.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; wdata_i = 32'h0BAD_F00D;
    size_i = 2'b10; unsigned_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    chk("rst_pre_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b0;
    #1;
    chk("rst_busy", 32'({busy_o, ready_o, err_addr_o, err_mis_o}), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    acc_a = 1'b0; acc_m = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_hold_busy", 32'(busy_o), 32'h0);
    rst_i = 1'b1;
    run(mk(1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 32'h55AA_55AA, 3, 1'b0, 1'b0), "rst_load");

    // Overflow followed by good accesses: error flag clears, or holds when sticky.
    run(mk(1'b1, 32'h0000_0400, 32'h3333_3333, 2'b10, 1'b0, 32'h0, 1, 1'b1, 1'b0), "ovf2");
    v = mk(1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 32'h1234_BEEF, 3, 1'b0, 1'b0);
    run(v, "post_ovf_a");
    run(v, "post_ovf_b");
    run(mk(1'b0, 32'h0000_0000, 32'h0, 2'b10, 1'b0, 32'h1111_1111, 3, 1'b0, 1'b0), "alias_chk");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before each memory access (0..15).
REQ-003 SHALL have clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_i  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have addr_i  input  32  byte address.
REQ-008 SHALL have wdata_i  input  32  store data, right-aligned.
REQ-009 SHALL have size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SHALL have unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have busy_o  output  1  high in every state except IDLE.
REQ-012 SHALL have ready_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have rdata_o  output  32  load result, valid while ready_o is high.
REQ-014 SHALL have err_addr_o  output  1  address overflow flag.
REQ-015 SHALL have err_mis_o  output  1  misalignment flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-017 SHALL, in IDLE with req_i=1, latch we_i/addr_i/size_i/wdata_i/unsigned_i; later input changes are ignored until the next IDLE.
REQ-018 SHALL evaluate errors on latched values: overflow = addr >= 4*DEPTH_WORDS; misalign = (half and addr[0]) or (word and addr[1:0]!=0) or size 11.
REQ-019 SHALL go IDLE->RESP on any error, skipping all memory access; a store SHALL NOT modify memory.
REQ-020 SHALL otherwise go IDLE->WAIT when WAIT_STATES>0 (stay WAIT_STATES cycles via down-counter), or IDLE->ACCESS when WAIT_STATES=0.
REQ-021 SHALL, in ACCESS, read the word at addr[log2(DEPTH_WORDS)+1:2]; a store writes only the addressed byte lanes (little-endian, lane = addr[1:0]); then go to RESP.
REQ-022 SHALL, in RESP, assert ready_o for exactly one cycle, then return to IDLE.
REQ-023 SHALL drive rdata_o on a load as the addressed byte/halfword, extended per unsigned_i; word loads are unmodified; rdata_o SHALL be 0 on stores and on errors.
REQ-024 SHALL give request-to-ready latency WAIT_STATES+2 cycles on success and 1 cycle on error.
REQ-025 SHALL drive err_addr_o/err_mis_o valid with ready_o; both may be set together.
REQ-026 SHALL ignore req_i while busy_o=1; back-to-back requests SHALL be accepted no earlier than the cycle after ready_o.

Reset
REQ-027 SHALL, on rst_i low, force IDLE, clear the counter, and drive busy_o, ready_o, rdata_o, err_addr_o, err_mis_o to 0.
REQ-028 SHALL abort any in-flight access on reset before the ACCESS edge, with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-029 SHALL support macro DMEM_ERR_STICKY_EN: when defined, error flags, once set, hold until reset.
REQ-030 SHALL, without DMEM_ERR_STICKY_EN, update error flags per access and clear them in the cycle after RESP.

Structure
REQ-031 SHALL place size encodings, FSM state enum, and the wait-counter width constant in package dmem_pkg.
REQ-032 SHALL contain one combinational sub-module dmem_lane_align performing load extract/extend and store lane merge.

Verification
REQ-033 Word store 0xDEADBEEF to 0x10, then word load 0x10 with WAIT_STATES=1 -> rdata_o=0xDEADBEEF, ready_o 3 cycles after req.
REQ-034 Byte store 0x80 to 0x13, then signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word 0x10 -> 0x80ADBEEF.
REQ-035 Halfword load at 0x11 -> err_mis_o=1, ready_o after 1 cycle, rdata_o=0, memory unchanged.
REQ-036 Word store to 0x400 with DEPTH_WORDS=256 -> err_addr_o=1, no write; with DMEM_ERR_STICKY_EN, flag stays 1 through later good accesses.
REQ-037 rst_i low during WAIT of store to 0x20 -> busy_o=0 immediately; subsequent load 0x20 returns prior contents.
